// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for multicycle_cpu. Holds the opcode and
//               function-code constants, the control state encoding and the
//               ALU operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;

    // R-type function codes, instruction bits [5:0]
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_XOR   = 6'b100110;
    localparam logic [5:0] c_FN_NOR   = 6'b100111;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_SLTU  = 6'b101011;
    localparam logic [5:0] c_FN_SLLV  = 6'b000100;

    // Control state encoding
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // ALU operation encoding
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLLV = 4'd8
    } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_alu
// Description : Purely combinational 32-bit ALU for multicycle_cpu.
// Ports       : i_a, i_b   - operands (SLLV shifts i_b left by i_a[4:0])
//               i_alu_op   - operation select
//               o_result   - 32-bit result
//               o_zf       - result is zero
//               o_of       - signed overflow (ADD/SUB only, else 0)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_t     i_alu_op,
    output logic [31:0] o_result,
    output logic        o_zf,
    output logic        o_of
);

    always_comb begin
        o_result = 32'd0;
        o_of     = 1'b0;
        case (i_alu_op)
            ALU_ADD: begin
                o_result = i_a + i_b;
                // Overflow: operands share a sign the result does not
                o_of     = (i_a[31] == i_b[31]) && (o_result[31] != i_a[31]);
            end
            ALU_SUB: begin
                o_result = i_a - i_b;
                // Overflow: operands differ in sign and result took b's sign
                o_of     = (i_a[31] != i_b[31]) && (o_result[31] != i_a[31]);
            end
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLT:  o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {31'd0, (i_a < i_b)};
            ALU_SLLV: o_result = i_b << i_a[4:0];
            default:  o_result = 32'd0;
        endcase
        o_zf = (o_result == 32'd0);
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_cpu
// Description : Multi-cycle 32-bit MIPS-style core (R/I ALU ops, lw/sw,
//               beq/bne, j, halt) with FETCH/DECODE/EXEC/MEM/WB control and
//               req/ack instruction and data memory ports.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               imem_*              - instruction fetch handshake
//               dmem_*              - data load/store handshake
//               pc                  - current program counter
//               halted, illegal     - stop status
//               dbg_sel, dbg_data   - debug mux (last WB value or {OF,ZF})
//               zf, of              - flags of last ALU-class instruction
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8,
    parameter int          DMEM_AW  = 8,
    parameter int          NUM_REGS = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ack,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ack,
    output logic [31:0]        pc,
    output logic               halted,
    output logic               illegal,
    input  logic               dbg_sel,
    output logic [31:0]        dbg_data,
    output logic               zf,
    output logic               of
);

    localparam int c_RIDX_W = $clog2(NUM_REGS);

    state_t                r_state, w_next_state;
    logic                  r_run;
    logic [31:0]           r_pc, r_ir, r_a, r_b, r_imm, r_alu_out, r_mdr, r_last_wb;
    logic                  r_zf, r_of, r_illegal;
    logic [31:0]           r_regs [NUM_REGS];

    // Instruction fields; register indices keep only the low c_RIDX_W bits
    logic [5:0]            w_op, w_func;
    logic [15:0]           w_imm16;
    logic [25:0]           w_target;
    logic [c_RIDX_W-1:0]   w_rs, w_rt, w_rd, w_wr_idx;

    logic                  w_legal, w_is_halt, w_is_j, w_is_branch;
    logic                  w_is_lw, w_is_sw, w_is_rtype, w_use_imm, w_zext, w_flag_wr;
    alu_op_t               w_alu_op;
    logic [31:0]           w_alu_b, w_alu_result, w_wb_val;
    logic                  w_alu_zf, w_alu_of, w_take;

    assign w_op     = r_ir[31:26];
    assign w_func   = r_ir[5:0];
    assign w_imm16  = r_ir[15:0];
    assign w_target = r_ir[25:0];
    assign w_rs     = r_ir[21 +: c_RIDX_W];
    assign w_rt     = r_ir[16 +: c_RIDX_W];
    assign w_rd     = r_ir[11 +: c_RIDX_W];

    // Instruction classification from the latched IR
    always_comb begin
        w_legal     = 1'b1;
        w_is_halt   = 1'b0;
        w_is_j      = 1'b0;
        w_is_branch = 1'b0;
        w_is_lw     = 1'b0;
        w_is_sw     = 1'b0;
        w_is_rtype  = 1'b0;
        w_use_imm   = 1'b0;
        w_zext      = 1'b0;
        w_flag_wr   = 1'b0;
        w_alu_op    = ALU_ADD;
        case (w_op)
            c_OP_RTYPE: begin
                w_is_rtype = 1'b1;
                w_flag_wr  = 1'b1;
                case (w_func)
                    c_FN_ADD:  w_alu_op = ALU_ADD;
                    c_FN_SUB:  w_alu_op = ALU_SUB;
                    c_FN_AND:  w_alu_op = ALU_AND;
                    c_FN_OR:   w_alu_op = ALU_OR;
                    c_FN_XOR:  w_alu_op = ALU_XOR;
                    c_FN_NOR:  w_alu_op = ALU_NOR;
                    c_FN_SLT:  w_alu_op = ALU_SLT;
                    c_FN_SLTU: w_alu_op = ALU_SLTU;
                    c_FN_SLLV: w_alu_op = ALU_SLLV;
                    default:   w_legal  = 1'b0;
                endcase
            end
            c_OP_ADDI: begin w_alu_op = ALU_ADD; w_use_imm = 1'b1; w_flag_wr = 1'b1; end
            c_OP_SLTI: begin w_alu_op = ALU_SLT; w_use_imm = 1'b1; w_flag_wr = 1'b1; end
            c_OP_ANDI: begin w_alu_op = ALU_AND; w_use_imm = 1'b1; w_zext = 1'b1; w_flag_wr = 1'b1; end
            c_OP_ORI:  begin w_alu_op = ALU_OR;  w_use_imm = 1'b1; w_zext = 1'b1; w_flag_wr = 1'b1; end
            c_OP_XORI: begin w_alu_op = ALU_XOR; w_use_imm = 1'b1; w_zext = 1'b1; w_flag_wr = 1'b1; end
            c_OP_LW:   begin w_alu_op = ALU_ADD; w_use_imm = 1'b1; w_is_lw = 1'b1; end
            c_OP_SW:   begin w_alu_op = ALU_ADD; w_use_imm = 1'b1; w_is_sw = 1'b1; end
            c_OP_BEQ,
            c_OP_BNE:  begin w_alu_op = ALU_SUB; w_is_branch = 1'b1; end
            c_OP_J:    w_is_j    = 1'b1;
            c_OP_HALT: w_is_halt = 1'b1;
            default:   w_legal   = 1'b0;
        endcase
    end

    assign w_alu_b = w_use_imm ? r_imm : r_b;

    cpu_alu u_alu (
        .i_a      (r_a),
        .i_b      (w_alu_b),
        .i_alu_op (w_alu_op),
        .o_result (w_alu_result),
        .o_zf     (w_alu_zf),
        .o_of     (w_alu_of)
    );

    assign w_take   = (w_op == c_OP_BEQ) ? w_alu_zf : ~w_alu_zf;
    assign w_wr_idx = w_is_rtype ? w_rd : w_rt;
    assign w_wb_val = w_is_lw ? r_mdr : r_alu_out;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:  if (imem_req && imem_ack) w_next_state = DECODE;
            DECODE: begin
                if (!w_legal || w_is_halt) w_next_state = HALT;
                else if (w_is_j)           w_next_state = FETCH;
                else                       w_next_state = EXEC;
            end
            EXEC: begin
                if (w_is_branch)             w_next_state = FETCH;
                else if (w_is_lw || w_is_sw) w_next_state = MEM;
                else                         w_next_state = WB;
            end
            MEM:    if (dmem_ack) w_next_state = w_is_lw ? WB : FETCH;
            WB:     w_next_state = FETCH;
            HALT:   w_next_state = HALT;
            default: w_next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    // Datapath registers. r_run holds off the first fetch request for one
    // cycle after reset so an ack left over from an abandoned fetch is never
    // mistaken for the response to the restarted one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run     <= 1'b0;
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_imm     <= 32'd0;
            r_alu_out <= 32'd0;
            r_mdr     <= 32'd0;
            r_last_wb <= 32'd0;
            r_zf      <= 1'b0;
            r_of      <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        r_ir <= imem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= w_zext ? {16'd0, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
                    if (!w_legal) r_illegal <= 1'b1;
                    if (w_legal && w_is_j) r_pc <= {r_pc[31:28], w_target, 2'b00};
                end
                EXEC: begin
                    r_alu_out <= w_alu_result;
                    if (w_flag_wr) begin
                        r_zf <= w_alu_zf;
                        r_of <= w_alu_of;
                    end
                    // pc already points past the branch
                    if (w_is_branch && w_take) r_pc <= r_pc + {r_imm[29:0], 2'b00};
                end
                MEM: begin
                    if (dmem_ack && w_is_lw) r_mdr <= dmem_rdata;
                end
                WB: begin
                    if (w_wr_idx != '0) r_regs[w_wr_idx] <= w_wb_val;
                    r_last_wb <= w_wb_val;
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = (r_state == FETCH) && r_run;
    assign imem_addr  = r_pc[IMEM_AW+1:2];
    assign dmem_req   = (r_state == MEM);
    assign dmem_we    = (r_state == MEM) && w_is_sw;
    assign dmem_addr  = r_alu_out[DMEM_AW+1:2];
    assign dmem_wdata = r_b;
    assign pc         = r_pc;
    assign halted     = (r_state == HALT);
    assign illegal    = r_illegal;
    assign zf         = r_zf;
    assign of         = r_of;
    assign dbg_data   = dbg_sel ? {30'd0, r_of, r_zf} : r_last_wb;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_cpu
// Description : Directed self-checking bench for multicycle_cpu with
//               behavioural instruction/data memories of settable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_cpu;

    localparam logic [5:0] c_ADDI = 6'h08, c_LW = 6'h23, c_SW = 6'h2B;
    localparam logic [5:0] c_BEQ  = 6'h04, c_BNE = 6'h05, c_J = 6'h02;
    localparam logic [5:0] c_FADD = 6'h20, c_FSUB = 6'h22, c_FNOR = 6'h27, c_FSLLV = 6'h04;
    localparam logic [31:0] c_HALTW = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [7:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, pc, dbg_data;
    logic        halted, illegal, dbg_sel, zf, of;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int          imem_lat, dmem_lat, icnt = 0, dcnt = 0;
    logic        imem_hold, imem_force;

    int          total = 0, bad = 0;
    int          cycles, nfetch, d_rises, d_unstable, n;
    logic        timed_out;
    logic [7:0]  fetch_q [16];
    logic [7:0]  st_addr;
    logic [31:0] st_wdata;

    multicycle_cpu #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (8),
        .DMEM_AW  (8),
        .NUM_REGS (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .zf         (zf),
        .of         (of)
    );

    always #5 clk = ~clk;

    // Memory responders: ack after imem_lat/dmem_lat wait cycles
    assign imem_rdata = imem[imem_addr];
    assign imem_ack   = imem_force | (imem_req & ~imem_hold & (icnt >= imem_lat));
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_ack   = dmem_req & (dcnt >= dmem_lat);

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    function automatic logic [31:0] rt_i(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = c_HALTW;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_hold = 1'b0; imem_force = 1'b0; dbg_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; cycles counts from the first imem_req cycle.
    task automatic run(input int max_cycles);
        logic       prev_d, h_we;
        logic [7:0] h_addr;
        logic [31:0] h_wd;
        prev_d = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
        nfetch = 0; d_rises = 0; d_unstable = 0; cycles = 0;
        st_addr = '0; st_wdata = '0;
        while (!imem_req && cycles < max_cycles) begin @(negedge clk); cycles++; end
        cycles = 0;
        while (!halted && cycles < max_cycles) begin
            if (imem_req && imem_ack && nfetch < 16) begin
                fetch_q[nfetch] = imem_addr;
                nfetch++;
            end
            if (dmem_req) begin
                if (!prev_d) begin
                    d_rises++; h_addr = dmem_addr; h_wd = dmem_wdata; h_we = dmem_we;
                end else if (dmem_addr !== h_addr || dmem_wdata !== h_wd || dmem_we !== h_we)
                    d_unstable++;
                if (dmem_ack && dmem_we) begin st_addr = dmem_addr; st_wdata = dmem_wdata; end
            end
            prev_d = dmem_req;
            @(negedge clk);
            cycles++;
        end
        timed_out = !halted;
    endtask

    initial begin
        reset = 1'b1; dbg_sel = 1'b0; imem_hold = 1'b0; imem_force = 1'b0;
        imem_lat = 0; dmem_lat = 0;

        // ---- Reset state ----
        clear_imem();
        do_reset();
        check("rst_halted",  {31'd0, halted},   32'd0);
        check("rst_illegal", {31'd0, illegal},  32'd0);
        check("rst_imemreq", {31'd0, imem_req}, 32'd0);
        check("rst_dmemreq", {31'd0, dmem_req}, 32'd0);
        check("rst_pc",      pc,                32'd0);
        check("rst_dbg",     dbg_data,          32'd0);
        check("rst_flags",   {30'd0, of, zf},   32'd0);

        // ---- Test 1: addi/addi/add/halt ----
        clear_imem();
        imem[0] = it_i(c_ADDI, 0, 1, 16'd5);
        imem[1] = it_i(c_ADDI, 0, 2, 16'd7);
        imem[2] = rt_i(1, 2, 3, c_FADD);
        do_reset();
        run(100);
        check("t1_cycles",  cycles,             32'd14);
        check("t1_r3",      dbg_data,           32'd12);
        check("t1_halted",  {31'd0, halted},    32'd1);
        check("t1_illegal", {31'd0, illegal},   32'd0);

        // ---- Test 2a: build 0x7FFFFFFF, add overflow ----
        clear_imem();
        imem[0] = it_i(c_ADDI, 0, 3, 16'd31);
        imem[1] = it_i(c_ADDI, 0, 4, 16'd1);
        imem[2] = rt_i(3, 4, 5, c_FSLLV);
        imem[3] = rt_i(5, 0, 1, c_FNOR);
        imem[4] = rt_i(1, 1, 4, c_FADD);
        do_reset();
        run(200);
        check("t2_add_res", dbg_data,         32'hFFFF_FFFE);
        check("t2_add_of",  {31'd0, of},      32'd1);
        check("t2_add_zf",  {31'd0, zf},      32'd0);
        dbg_sel = 1'b1; #1;
        check("t2_add_dbg1", dbg_data,        32'h2);

        // ---- Test 2b: sub to zero ----
        imem[4] = rt_i(1, 1, 5, c_FSUB);
        do_reset();
        run(200);
        check("t2_sub_res", dbg_data,         32'd0);
        check("t2_sub_zf",  {31'd0, zf},      32'd1);
        check("t2_sub_of",  {31'd0, of},      32'd0);
        dbg_sel = 1'b1; #1;
        check("t2_sub_dbg1", dbg_data,        32'h1);
        dbg_sel = 1'b0;

        // ---- Test 3: sw/lw with 3 wait states ----
        clear_imem();
        imem[0] = it_i(c_ADDI, 0, 3, 16'd12);
        imem[1] = it_i(c_SW, 0, 3, 16'd8);
        imem[2] = it_i(c_LW, 0, 6, 16'd8);
        dmem_lat = 3;
        do_reset();
        run(200);
        check("t3_cycles",   cycles,          32'd21);
        check("t3_rises",    d_rises,         32'd2);
        check("t3_unstable", d_unstable,      32'd0);
        check("t3_st_addr",  {24'd0, st_addr}, 32'd2);
        check("t3_st_wdata", st_wdata,        32'd12);
        check("t3_r6",       dbg_data,        32'd12);
        dmem_lat = 0;

        // ---- Test 4: j, bne not taken, beq loop ----
        clear_imem();
        imem[0]    = it_i(c_ADDI, 0, 1, 16'd3);
        imem[1]    = {c_J, 26'h10};
        imem[8'h10] = {c_J, 26'h4};
        imem[4]    = it_i(c_BNE, 1, 1, 16'd4);
        imem[5]    = it_i(c_BEQ, 1, 1, 16'hFFFF);
        do_reset();
        run(60);
        check("t4_loops",  {31'd0, timed_out}, 32'd1);
        check("t4_halted", {31'd0, halted},    32'd0);
        check("t4_f0", {24'd0, fetch_q[0]}, 32'h00);
        check("t4_f1", {24'd0, fetch_q[1]}, 32'h01);
        check("t4_f2_j", {24'd0, fetch_q[2]}, 32'h10);
        check("t4_f3_j", {24'd0, fetch_q[3]}, 32'h04);
        check("t4_f4_bne", {24'd0, fetch_q[4]}, 32'h05);
        check("t4_f5_beq", {24'd0, fetch_q[5]}, 32'h05);
        check("t4_f6_beq", {24'd0, fetch_q[6]}, 32'h05);

        // ---- Test 5a: reg-0 write updates last_wb ----
        clear_imem();
        imem[0] = it_i(c_ADDI, 0, 0, 16'd9);
        do_reset();
        run(100);
        check("t5_wb_r0", dbg_data, 32'd9);

        // ---- Test 5b: r0 stays 0, illegal opcode halts ----
        imem[1] = rt_i(0, 0, 7, c_FADD);
        imem[2] = {6'b010101, 26'd0};
        do_reset();
        run(100);
        check("t5_r0_zero", dbg_data,         32'd0);
        check("t5_halted",  {31'd0, halted},  32'd1);
        check("t5_illegal", {31'd0, illegal}, 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req || dmem_req) n++;
        end
        check("t5_no_req", n, 32'd0);

        // ---- Test 5c: illegal R-type function ----
        clear_imem();
        imem[0] = rt_i(0, 0, 1, 6'b000001);
        do_reset();
        run(100);
        check("t5c_illegal", {31'd0, illegal}, 32'd1);

        // ---- Test 6: reset during a pending fetch ----
        clear_imem();
        imem[0] = it_i(c_ADDI, 0, 1, 16'd5);
        do_reset();
        n = 0;
        while (dbg_data !== 32'd5 && n < 30) begin @(negedge clk); n++; end
        imem_hold = 1'b1;
        check("t6_wb5", dbg_data, 32'd5);
        repeat (3) @(negedge clk);
        check("t6_waiting", {31'd0, imem_req}, 32'd1);
        check("t6_addr1", {24'd0, imem_addr}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        imem_force = 1'b1;
        imem[0] = rt_i(1, 0, 2, c_FADD);
        check("t6_req_off", {31'd0, imem_req}, 32'd0);
        check("t6_pc_rst", pc, 32'd0);
        check("t6_wb_rst", dbg_data, 32'd0);
        @(negedge clk);
        imem_force = 1'b0;
        imem_hold = 1'b0;
        check("t6_pc_kept", pc, 32'd0);
        check("t6_req_on", {31'd0, imem_req}, 32'd1);
        run(100);
        check("t6_f0", {24'd0, fetch_q[0]}, 32'd0);
        check("t6_regs_clr", dbg_data, 32'd0);
        check("t6_halted", {31'd0, halted}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
